clock_switch_seq: RTL and testbench
===================================

# clock_switch_seq

Sequencer that owns the configuration inputs of the clock routing block (source select and all four divider settings) and applies a requested configuration safely. It parks the core clock on the external pad clock, loads the new divider values, waits for DLL lock, lets the dividers settle, then releases to the requested source. It sits between the housekeeping register interface (request/ready handshake) and the clock routing block, and is clocked by the DLL clock.

## Interface
- SETTLE_CYCLES, 16: dll_clk cycles to wait after parking and after lock, before the next step; must be ≥ 4.
- LOCK_TIMEOUT, 1024: maximum dll_clk cycles spent waiting for DLL lock per request.
- dll_clk  in  1  DLL clock; all state is on its rising edge.
- resetb  in  1  reset, asynchronous, active-low.
- req_valid  in  1  configuration request valid.
- req_ready  out  1  high in IDLE only.
- req_ext_sel  in  1  requested source: 1 = external pad clock, 0 = DLL.
- req_sel, req_sel2  in  3 each  requested core / aux primary divider values.
- req_auxdiv, req_primdiv  in  8 each  requested aux / monitor secondary divider values.
- dll_lock  in  1  DLL lock, asynchronous; 2-flop synchronized internally.
- ext_clk_sel  out  1  to clock routing; reset 1.
- sel, sel2  out  3 each  to clock routing; reset 0.
- auxdiv, primdiv  out  8 each  to clock routing; reset 0.
- busy  out  1  high in every state except IDLE; reset 0.
- done  out  1  one-cycle pulse when a request completes; reset 0.
- lock_err  out  1  sticky; set on lock timeout, cleared when the next request is accepted; reset 0.

## Operation
- States: IDLE, PARK, APPLY, LOCK_WAIT, SETTLE.
- IDLE: req_ready=1. When req_valid=1, capture all req_* fields into shadow registers and clear lock_err and the timeout counter. Go to PARK if ext_clk_sel=0; go to APPLY if ext_clk_sel=1.
- PARK: drive ext_clk_sel=1 and hold for SETTLE_CYCLES cycles. This covers the two-stage select synchronizer in clock routing. Then go to APPLY.
- APPLY: one cycle. Load sel, sel2, auxdiv and primdiv from the shadow registers. Next state:
  - IDLE with done pulse if shadow ext_sel=1;
  - LOCK_WAIT if shadow ext_sel=0.
- LOCK_WAIT: increment the timeout counter each cycle.
  - When synchronized lock=1, go to SETTLE.
  - When the counter reaches LOCK_TIMEOUT: set lock_err, pulse done, leave ext_clk_sel=1, go to IDLE.
- SETTLE: count SETTLE_CYCLES cycles.
  - If synchronized lock drops, return to LOCK_WAIT. The timeout counter is not cleared, so the budget covers the whole request.
  - On the final cycle, ext_clk_sel←0, pulse done, go to IDLE.
- Outputs to clock routing change only as listed above; they never change in IDLE.
- A new request is never accepted while busy=1. req_* values presented while busy are ignored.

## Timing
- Accept is the edge where req_valid & req_ready. busy rises and req_ready falls on that edge.
- Already external, target DLL, lock already synchronized high (accept edge E0):
  - dividers update at E1;
  - SETTLE entered at E2;
  - ext_clk_sel falls and done rises at E2+SETTLE_CYCLES;
  - busy falls on that same edge.
- Starting on DLL: add SETTLE_CYCLES for PARK. ext_clk_sel rises at E0+1.
- Synchronizer latency: 2 cycles from dll_lock to its internal use.
- Reset asserted mid-sequence: all outputs return asynchronously to their reset values (external source, dividers 0) and the state goes to IDLE. A request in flight is discarded.
- Timeout counter width is clog2(LOCK_TIMEOUT+1). It never wraps; it saturates at LOCK_TIMEOUT.

## Structure
- Shared package clock_pkg holds:
  - the state encoding typedef;
  - the divider widths (3 for primary, 8 for secondary);
  - the default SETTLE_CYCLES and LOCK_TIMEOUT constants.
- One sub-module, sync2: a 2-flop synchronizer with asynchronous active-low reset to 0, used for dll_lock.

## Test plan
- Reset, then a request {ext_sel=0, sel=2, sel2=1, auxdiv=5, primdiv=10} with dll_lock=1:
  - dividers update 1 cycle after accept;
  - ext_clk_sel falls 2+16 cycles after accept, with done in the same cycle.
- From DLL source, request sel=3:
  - ext_clk_sel=1 for at least 16 cycles before sel changes;
  - ext_clk_sel returns to 0 afterwards.
- dll_lock held 0, target DLL:
  - after 1024 LOCK_WAIT cycles, lock_err=1, done pulses, ext_clk_sel stays 1;
  - the next accepted request clears lock_err.
- dll_lock drops for 3 cycles mid-SETTLE:
  - returns to LOCK_WAIT, and the settle count restarts after relock;
  - the total wait still respects the 1024-cycle budget.
- req_valid held during busy with changing data: only the first request is applied; req_ready=0 until done.
- resetb pulsed low during PARK: ext_clk_sel=1, dividers=0, busy=0 immediately; the next request works normally.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding, divider widths and default timing constants for clock switching.
package clock_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PARK, S_APPLY, S_LOCK_WAIT, S_SETTLE} state_t;
  localparam int PRIM_W = 3;
  localparam int SEC_W = 8;
  localparam int SETTLE_CYCLES_DEF = 16;
  localparam int LOCK_TIMEOUT_DEF = 1024;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer, asynchronous active-low reset to 0.
module sync2 (
  input  logic dll_clk,
  input  logic resetb,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_ff;
  always_ff @(posedge dll_clk or negedge resetb)
    if (!resetb) r_ff <= '0;
    else r_ff <= {r_ff[0], i_d};
  assign o_q = r_ff[1];
endmodule

// File: rtl/clock_switch_seq.sv
// clock_switch_seq: parks the core clock on the pad clock, loads dividers, waits for DLL lock, then releases.
module clock_switch_seq
  import clock_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic              dll_clk,
  input  logic              resetb,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_ext_sel,
  input  logic [PRIM_W-1:0] i_req_sel,
  input  logic [PRIM_W-1:0] i_req_sel2,
  input  logic [SEC_W-1:0]  i_req_auxdiv,
  input  logic [SEC_W-1:0]  i_req_primdiv,
  input  logic              i_dll_lock,
  output logic              o_ext_clk_sel,
  output logic [PRIM_W-1:0] o_sel,
  output logic [PRIM_W-1:0] o_sel2,
  output logic [SEC_W-1:0]  o_auxdiv,
  output logic [SEC_W-1:0]  o_primdiv,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_lock_err
);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  state_t r_state;
  logic r_ext, r_done, r_lock_err, r_sh_ext;
  logic [PRIM_W-1:0] r_sel, r_sel2, r_sh_sel, r_sh_sel2;
  logic [SEC_W-1:0] r_aux, r_prim, r_sh_aux, r_sh_prim;
  logic [TW-1:0] r_to_cnt;
  logic [SW-1:0] r_st_cnt;
  logic w_lock, w_st_last;
  logic [TW-1:0] w_to_next;
  sync2 u_lock_sync (.dll_clk(dll_clk), .resetb(resetb), .i_d(i_dll_lock), .o_q(w_lock));
  // Timeout budget spans the whole request, so it saturates rather than wraps.
  assign w_to_next = (r_to_cnt == TW'(LOCK_TIMEOUT)) ? r_to_cnt : r_to_cnt + 1'b1;
  assign w_st_last = r_st_cnt == SW'(SETTLE_CYCLES - 1);
  always_ff @(posedge dll_clk or negedge resetb)
    if (!resetb) begin
      r_state <= S_IDLE;
      r_ext <= 1'b1;
      r_sel <= '0;
      r_sel2 <= '0;
      r_aux <= '0;
      r_prim <= '0;
      r_sh_ext <= 1'b1;
      r_sh_sel <= '0;
      r_sh_sel2 <= '0;
      r_sh_aux <= '0;
      r_sh_prim <= '0;
      r_to_cnt <= '0;
      r_st_cnt <= '0;
      r_done <= 1'b0;
      r_lock_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_req_valid) begin
          r_sh_ext <= i_req_ext_sel;
          r_sh_sel <= i_req_sel;
          r_sh_sel2 <= i_req_sel2;
          r_sh_aux <= i_req_auxdiv;
          r_sh_prim <= i_req_primdiv;
          r_lock_err <= 1'b0;
          r_to_cnt <= '0;
          r_st_cnt <= '0;
          r_state <= r_ext ? S_APPLY : S_PARK;
        end
        S_PARK: begin
          r_ext <= 1'b1;
          r_st_cnt <= w_st_last ? '0 : r_st_cnt + 1'b1;
          if (w_st_last) r_state <= S_APPLY;
        end
        S_APPLY: begin
          r_sel <= r_sh_sel;
          r_sel2 <= r_sh_sel2;
          r_aux <= r_sh_aux;
          r_prim <= r_sh_prim;
          r_done <= r_sh_ext;
          r_state <= r_sh_ext ? S_IDLE : S_LOCK_WAIT;
        end
        S_LOCK_WAIT: begin
          r_to_cnt <= w_to_next;
          if (w_lock) begin
            r_st_cnt <= '0;
            r_state <= S_SETTLE;
          end else if (w_to_next == TW'(LOCK_TIMEOUT)) begin
            r_lock_err <= 1'b1;
            r_done <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_SETTLE:
          if (!w_lock) r_state <= S_LOCK_WAIT;
          else if (w_st_last) begin
            r_ext <= 1'b0;
            r_done <= 1'b1;
            r_state <= S_IDLE;
          end else r_st_cnt <= r_st_cnt + 1'b1;
        default: r_state <= S_IDLE;
      endcase
    end
  assign o_req_ready = r_state == S_IDLE;
  assign o_busy = r_state != S_IDLE;
  assign o_ext_clk_sel = r_ext;
  assign o_sel = r_sel;
  assign o_sel2 = r_sel2;
  assign o_auxdiv = r_aux;
  assign o_primdiv = r_prim;
  assign o_done = r_done;
  assign o_lock_err = r_lock_err;
endmodule

// File: tb/tb_clock_switch_seq.sv
// tb_clock_switch_seq: directed sequence with hand-computed expectations for the clock switch sequencer.
module tb_clock_switch_seq;
  logic dll_clk = 1'b0, resetb, req_valid, req_ready, req_ext_sel, dll_lock;
  logic ext_clk_sel, busy, done, lock_err;
  logic [2:0] req_sel, req_sel2, sel, sel2;
  logic [7:0] req_auxdiv, req_primdiv, auxdiv, primdiv;
  int n_chk = 0, n_pass = 0;
  always #5 dll_clk = ~dll_clk;
  clock_switch_seq dut (
    .dll_clk(dll_clk), .resetb(resetb), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_ext_sel(req_ext_sel), .i_req_sel(req_sel), .i_req_sel2(req_sel2),
    .i_req_auxdiv(req_auxdiv), .i_req_primdiv(req_primdiv), .i_dll_lock(dll_lock),
    .o_ext_clk_sel(ext_clk_sel), .o_sel(sel), .o_sel2(sel2), .o_auxdiv(auxdiv),
    .o_primdiv(primdiv), .o_busy(busy), .o_done(done), .o_lock_err(lock_err)
  );
  task automatic tick(input int n);
    repeat (n) @(posedge dll_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic req(input logic e, input logic [2:0] s, input logic [2:0] s2, input logic [7:0] a, input logic [7:0] p);
    req_valid = 1'b1;
    req_ext_sel = e;
    req_sel = s;
    req_sel2 = s2;
    req_auxdiv = a;
    req_primdiv = p;
  endtask
  initial begin
    resetb = 1'b0; dll_lock = 1'b1; req_valid = 1'b0; req_ext_sel = 1'b0;
    req_sel = '0; req_sel2 = '0; req_auxdiv = '0; req_primdiv = '0;
    tick(2);
    chk("rst_ext", ext_clk_sel, 1); chk("rst_sel", sel, 0); chk("rst_aux", auxdiv, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", lock_err, 0);
    chk("rst_ready", req_ready, 1);
    resetb = 1'b1; tick(3);
    // already external, locked: dividers at E1, release at E18
    req(0, 3'd2, 3'd1, 8'd5, 8'd10); tick(1); req_valid = 1'b0;
    chk("t1_busy", busy, 1); chk("t1_ready", req_ready, 0); chk("t1_sel_e0", sel, 0);
    tick(1);
    chk("t1_sel", sel, 2); chk("t1_sel2", sel2, 1); chk("t1_aux", auxdiv, 5); chk("t1_prim", primdiv, 10);
    chk("t1_ext_e1", ext_clk_sel, 1);
    tick(16); chk("t1_ext_e17", ext_clk_sel, 1); chk("t1_done_e17", done, 0);
    tick(1); chk("t1_ext_e18", ext_clk_sel, 0); chk("t1_done_e18", done, 1); chk("t1_busy_e18", busy, 0);
    tick(1); chk("t1_done_pulse", done, 0);
    // from DLL: park 16 cycles first
    req(0, 3'd3, 3'd1, 8'd5, 8'd10); tick(1); req_valid = 1'b0;
    chk("t2_ext_e0", ext_clk_sel, 0);
    tick(1); chk("t2_ext_e1", ext_clk_sel, 1); chk("t2_sel_e1", sel, 2);
    tick(15); chk("t2_sel_e16", sel, 2); chk("t2_ext_e16", ext_clk_sel, 1);
    tick(1); chk("t2_sel_e17", sel, 3);
    tick(16); chk("t2_ext_e33", ext_clk_sel, 1); chk("t2_done_e33", done, 0);
    tick(1); chk("t2_ext_e34", ext_clk_sel, 0); chk("t2_done_e34", done, 1);
    // lock never arrives: timeout at E17+1024
    dll_lock = 1'b0; req(0, 3'd4, 3'd1, 8'd5, 8'd10); tick(1); req_valid = 1'b0;
    tick(1040); chk("t3_done_early", done, 0); chk("t3_err_early", lock_err, 0); chk("t3_busy", busy, 1);
    tick(1);
    chk("t3_err", lock_err, 1); chk("t3_done", done, 1); chk("t3_ext", ext_clk_sel, 1);
    chk("t3_sel", sel, 4); chk("t3_idle", busy, 0);
    tick(1); chk("t3_done_pulse", done, 0); chk("t3_err_sticky", lock_err, 1);
    // external target clears lock_err on accept and completes at E1
    dll_lock = 1'b1; tick(3);
    req(1, 3'd5, 3'd1, 8'd5, 8'd10); tick(1); req_valid = 1'b0;
    chk("t4_err_clr", lock_err, 0); chk("t4_busy", busy, 1);
    tick(1); chk("t4_sel", sel, 5); chk("t4_done", done, 1); chk("t4_ext", ext_clk_sel, 1); chk("t4_idle", busy, 0);
    // lock drop mid-settle: relock seen at E13, release at E29
    req(0, 3'd6, 3'd1, 8'd5, 8'd10); tick(1); req_valid = 1'b0;
    tick(7); dll_lock = 1'b0;
    tick(3); dll_lock = 1'b1;
    chk("t5_busy", busy, 1); chk("t5_ext", ext_clk_sel, 1);
    tick(18); chk("t5_ext_e28", ext_clk_sel, 1); chk("t5_done_e28", done, 0);
    tick(1); chk("t5_ext_e29", ext_clk_sel, 0); chk("t5_done_e29", done, 1); chk("t5_err", lock_err, 0);
    // held request with changing data while busy
    req(0, 3'd7, 3'd2, 8'h11, 8'h44); tick(1);
    req_sel = 3'd1; req_auxdiv = 8'h22; req_primdiv = 8'h33; req_ext_sel = 1'b1;
    chk("t6_ready_e0", req_ready, 0);
    tick(17); chk("t6_sel", sel, 7); chk("t6_aux", auxdiv, 8'h11); chk("t6_prim", primdiv, 8'h44);
    chk("t6_ready_e17", req_ready, 0);
    tick(16); chk("t6_ready_e33", req_ready, 0); chk("t6_done_e33", done, 0);
    tick(1); req_valid = 1'b0;
    chk("t6_done", done, 1); chk("t6_sel_end", sel, 7); chk("t6_prim_end", primdiv, 8'h44);
    chk("t6_ready_end", req_ready, 1); chk("t6_ext_end", ext_clk_sel, 0);
    // reset during park
    req(0, 3'd2, 3'd2, 8'd9, 8'd9); tick(1); req_valid = 1'b0; tick(5);
    chk("t7_ext_park", ext_clk_sel, 1); chk("t7_busy_park", busy, 1);
    resetb = 1'b0; #1;
    chk("t7_rst_ext", ext_clk_sel, 1); chk("t7_rst_sel", sel, 0); chk("t7_rst_sel2", sel2, 0);
    chk("t7_rst_aux", auxdiv, 0); chk("t7_rst_prim", primdiv, 0); chk("t7_rst_busy", busy, 0);
    chk("t7_rst_ready", req_ready, 1);
    tick(1); resetb = 1'b1; tick(3);
    req(0, 3'd3, 3'd2, 8'd7, 8'd8); tick(1); req_valid = 1'b0;
    chk("t7_busy", busy, 1);
    tick(1); chk("t7_sel", sel, 3); chk("t7_sel2", sel2, 2); chk("t7_aux", auxdiv, 7); chk("t7_prim", primdiv, 8);
    tick(17); chk("t7_ext_end", ext_clk_sel, 0); chk("t7_done", done, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
